// File: rtl/wb_io_pkg.sv
// Shared definitions for the Wishbone GPIO controller.
// Holds the register offsets, the bus handshake state type, the default ID
// value and the byte-lane helpers used by the register writes.
package wb_io_pkg;

  localparam logic [7:0] REG_DOUT  = 8'h00;
  localparam logic [7:0] REG_OEB   = 8'h04;
  localparam logic [7:0] REG_DIN   = 8'h08;
  localparam logic [7:0] REG_IEN   = 8'h0C;
  localparam logic [7:0] REG_ISTAT = 8'h10;
  localparam logic [7:0] REG_ID    = 8'h14;

  localparam logic [31:0] DEFAULT_ID = 32'h4D50_0001;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  // Expands the four byte selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Replaces only the selected byte lanes of old with wdata.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    return (old & ~lane_mask(sel)) | (wdata & lane_mask(sel));
  endfunction

endpackage

// File: rtl/wb_io_ctrl_if.sv
// Wishbone slave bus bundle between the management SoC and the GPIO block.
// master drives cyc/stb/we/sel/adr/dat_i and receives ack/dat_o;
// slave is the mirror image.
interface wb_io_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/io_sync_edge.sv
// Pad input synchroniser with rising-edge detection.
// Ports: clk/rst (synchronous, active-high), d = asynchronous pad inputs,
// sync = d after two flops, rise = one-cycle pulse when sync goes 0 -> 1.
module io_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1, s2, s3;

  // s1/s2 form the metastability chain; s3 remembers the previous s2 so a
  // rising edge can be seen as s2 high while s3 is still low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/wb_io_ctrl.sv
// Wishbone-slave GPIO controller for the user project area.
// Ports: wb_clk_i clock, wb_rst_i synchronous active-high reset,
// wbs = Wishbone slave bus, io_in asynchronous pad inputs, io_out pad output
// values, io_oeb pad output-enable bars (1 = input), irq user interrupts
// (only irq[0] is used: any enabled latched rising edge).
module wb_io_ctrl
  import wb_io_pkg::*;
#(
  parameter int          NIO       = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = DEFAULT_ID
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_io_ctrl_if.slave    wbs,
  input  logic [NIO-1:0] io_in,
  output logic [NIO-1:0] io_out,
  output logic [NIO-1:0] io_oeb,
  output logic [2:0]     irq
);

  state_t         state, state_next;
  logic           hit, accept, do_write;
  logic [7:0]     offset;
  logic [NIO-1:0] dout, oeb, ien, istat;
  logic [NIO-1:0] din, rise, istat_clr;
  logic [31:0]    rdata, dat_q;

  io_sync_edge #(.WIDTH(NIO)) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (io_in),
    .sync (din),
    .rise (rise)
  );

  assign hit      = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset   = wbs.wbs_adr_i[7:0];
  assign do_write = accept && wbs.wbs_we_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // A request is taken only from IDLE, so a strobe still high during ACK is
  // ignored and a held strobe is serviced every other cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (wbs.wbs_cyc_i && wbs.wbs_stb_i && hit) begin
          accept     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // W1C mask, limited to the selected byte lanes.
  always_comb begin
    istat_clr = '0;
    if (do_write && offset == REG_ISTAT)
      istat_clr = NIO'(wbs.wbs_dat_i & lane_mask(wbs.wbs_sel_i));
  end

  // New edges are OR-ed in after the clear, so a set wins over a clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dout  <= '0;
      oeb   <= '1;
      ien   <= '0;
      istat <= '0;
    end else begin
      istat <= (istat & ~istat_clr) | rise;
      if (do_write) begin
        case (offset)
          REG_DOUT: dout <= NIO'(merge_lanes(32'(dout), wbs.wbs_dat_i, wbs.wbs_sel_i));
          REG_OEB:  oeb  <= NIO'(merge_lanes(32'(oeb),  wbs.wbs_dat_i, wbs.wbs_sel_i));
          REG_IEN:  ien  <= NIO'(merge_lanes(32'(ien),  wbs.wbs_dat_i, wbs.wbs_sel_i));
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_DOUT:  rdata = 32'(dout);
      REG_OEB:   rdata = 32'(oeb);
      REG_DIN:   rdata = 32'(din);
      REG_IEN:   rdata = 32'(ien);
      REG_ISTAT: rdata = 32'(istat);
      REG_ID:    rdata = ID_VALUE;
      default:   rdata = '0;
    endcase
  end

  // Read data is only valid during the ack cycle and is zero otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                       dat_q <= '0;
    else if (accept && !wbs.wbs_we_i)   dat_q <= rdata;
    else                                dat_q <= '0;
  end

  assign wbs.wbs_ack_o = (state == ACK);
  assign wbs.wbs_dat_o = dat_q;
  assign io_out        = dout;
  assign io_oeb        = oeb;
  assign irq           = {2'b00, |(istat & ien)};

endmodule

// File: tb/tb_wb_io_ctrl.sv
// Directed self-checking bench for wb_io_ctrl: reset values, byte-lane
// writes, held-strobe handshake, window decode, edge interrupts, set-vs-clear
// priority and reset in the middle of a transaction.
module tb_wb_io_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic [2:0]  irq;

  int compared;
  int mismatched;

  wb_io_ctrl_if bus ();

  wb_io_ctrl #(
    .NIO       (16),
    .BASE_ADDR (32'h3000_0000),
    .ID_VALUE  (32'h4D50_0001)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  // Single read; lat is the number of edges until ack (0 = never acked).
  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = addr;
    bus.wbs_dat_i = 32'h0;
    lat  = 0;
    data = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) begin
        lat  = i;
        data = bus.wbs_dat_o;
        break;
      end
    end
    bus_idle();
    tick();
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, output int lat);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = addr;
    bus.wbs_dat_i = data;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus_idle();
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    compared++;
    if (io_oeb !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL reset_oeb: got %h expected %h", io_oeb, 16'hFFFF);
    end
    compared++;
    if (io_out !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_out: got %h expected %h", io_out, 16'h0000);
    end
    compared++;
    if (irq !== 3'b000 || bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: irq %b ack %b dat %h expected 000 0 0",
               irq, bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_read(32'h3000_0014, rd, lat);
    compared++;
    if (rd !== 32'h4D50_0001) begin
      mismatched++;
      $display("[TB] FAIL read_id: got %h expected %h", rd, 32'h4D50_0001);
    end
    compared++;
    if (lat !== 1) begin
      mismatched++;
      $display("[TB] FAIL id_latency: got %0d expected 1", lat);
    end
    compared++;
    if (bus.wbs_dat_o !== 32'h0 || bus.wbs_ack_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dat_after_ack: dat %h ack %b expected 0 0",
               bus.wbs_dat_o, bus.wbs_ack_o);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    int lat;
    wb_write(32'h3000_0000, 32'h0000_A5C3, 4'b0001, lat);
    compared++;
    if (io_out !== 16'h00C3) begin
      mismatched++;
      $display("[TB] FAIL dout_lane0: got %h expected %h", io_out, 16'h00C3);
    end
    wb_write(32'h3000_0000, 32'h0000_A5C3, 4'b0010, lat);
    compared++;
    if (io_out !== 16'hA5C3) begin
      mismatched++;
      $display("[TB] FAIL dout_lane1: got %h expected %h", io_out, 16'hA5C3);
    end
    wb_read(32'h3000_0000, rd, lat);
    compared++;
    if (rd !== 32'h0000_A5C3) begin
      mismatched++;
      $display("[TB] FAIL dout_readback: got %h expected %h", rd, 32'h0000_A5C3);
    end
    wb_write(32'h3000_0004, 32'h0000_00F0, 4'hF, lat);
    compared++;
    if (io_oeb !== 16'h00F0) begin
      mismatched++;
      $display("[TB] FAIL oeb_write: got %h expected %h", io_oeb, 16'h00F0);
    end
    wb_write(32'h3000_000C, 32'hFFFF_FFFF, 4'hF, lat);
    wb_read(32'h3000_000C, rd, lat);
    compared++;
    if (rd !== 32'h0000_FFFF) begin
      mismatched++;
      $display("[TB] FAIL ien_upper_bits: got %h expected %h", rd, 32'h0000_FFFF);
    end
    wb_write(32'h3000_000C, 32'h0000_0000, 4'hF, lat);
    wb_read(32'h3000_0018, rd, lat);
    compared++;
    if (rd !== 32'h0 || lat !== 1) begin
      mismatched++;
      $display("[TB] FAIL unmapped_read: got %h lat %0d expected 0 lat 1", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pattern;
    int acks;
    logic saw_miss_ack;
    logic saw_miss_dat;
    pattern = '0;
    acks    = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0008;
    for (int i = 0; i < 6; i++) begin
      tick();
      pattern[i] = bus.wbs_ack_o;
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    bus_idle();
    tick();
    compared++;
    if (acks !== 3) begin
      mismatched++;
      $display("[TB] FAIL held_stb_ack_count: got %0d expected 3", acks);
    end
    compared++;
    if (pattern !== 6'b010101) begin
      mismatched++;
      $display("[TB] FAIL held_stb_ack_pattern: got %b expected %b", pattern, 6'b010101);
    end
    saw_miss_ack = 1'b0;
    saw_miss_dat = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0100;
    bus.wbs_dat_i = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wbs_ack_o !== 1'b0) saw_miss_ack = 1'b1;
      if (bus.wbs_dat_o !== 32'h0) saw_miss_dat = 1'b1;
    end
    bus_idle();
    tick();
    compared++;
    if (saw_miss_ack || saw_miss_dat) begin
      mismatched++;
      $display("[TB] FAIL window_miss_ack: ack seen %b dat seen %b expected 0 0",
               saw_miss_ack, saw_miss_dat);
    end
    compared++;
    if (io_out !== 16'hA5C3) begin
      mismatched++;
      $display("[TB] FAIL window_miss_side_effect: got %h expected %h", io_out, 16'hA5C3);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    int lat;
    wb_write(32'h3000_000C, 32'h0000_0008, 4'hF, lat);
    wb_write(32'h3000_0010, 32'h0000_FFFF, 4'hF, lat);
    io_in[3] = 1'b1;
    tick();
    compared++;
    if (dut.din[3] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL din_after_1_edge: got %b expected 0", dut.din[3]);
    end
    tick();
    compared++;
    if (dut.din !== 16'h0008 || irq !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL din_after_2_edges: din %h irq %b expected 0008 000", dut.din, irq);
    end
    tick();
    compared++;
    if (irq !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL irq_after_3_edges: got %b expected 001", irq);
    end
    wb_read(32'h3000_0010, rd, lat);
    compared++;
    if (rd !== 32'h0000_0008) begin
      mismatched++;
      $display("[TB] FAIL istat_set: got %h expected %h", rd, 32'h0000_0008);
    end
    wb_read(32'h3000_0008, rd, lat);
    compared++;
    if (rd !== 32'h0000_0008) begin
      mismatched++;
      $display("[TB] FAIL din_read: got %h expected %h", rd, 32'h0000_0008);
    end
    wb_write(32'h3000_0010, 32'h0000_0008, 4'hF, lat);
    compared++;
    if (irq !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL irq_after_w1c: got %b expected 000", irq);
    end
    wb_read(32'h3000_0010, rd, lat);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL istat_after_w1c: got %h expected 0", rd);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    int lat;
    io_in[5] = 1'b1;
    tick();
    tick();
    // Clear lands on the same edge that latches the new rise.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0010;
    bus.wbs_dat_i = 32'h0000_0020;
    tick();
    compared++;
    if (bus.wbs_ack_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL collide_ack: got %b expected 1", bus.wbs_ack_o);
    end
    bus_idle();
    tick();
    wb_read(32'h3000_0010, rd, lat);
    compared++;
    if (rd !== 32'h0000_0020) begin
      mismatched++;
      $display("[TB] FAIL set_wins: got %h expected %h", rd, 32'h0000_0020);
    end
    wb_write(32'h3000_0010, 32'h0000_0020, 4'b0010, lat);
    wb_read(32'h3000_0010, rd, lat);
    compared++;
    if (rd !== 32'h0000_0020) begin
      mismatched++;
      $display("[TB] FAIL w1c_unselected_lane: got %h expected %h", rd, 32'h0000_0020);
    end
    wb_write(32'h3000_0010, 32'h0000_0020, 4'b0001, lat);
    wb_read(32'h3000_0010, rd, lat);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL w1c_bit5: got %h expected 0", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0000;
    bus.wbs_dat_i = 32'h0000_1111;
    tick();
    compared++;
    if (bus.wbs_ack_o !== 1'b1 || io_out !== 16'h1111) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_write: ack %b out %h expected 1 1111",
               bus.wbs_ack_o, io_out);
    end
    rst = 1'b1;
    tick();
    compared++;
    if (bus.wbs_ack_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ack_after_reset: got %b expected 0", bus.wbs_ack_o);
    end
    tick();
    rst = 1'b0;
    bus_idle();
    tick();
    compared++;
    if (io_out !== 16'h0000 || io_oeb !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL regs_after_reset: out %h oeb %h expected 0000 ffff",
               io_out, io_oeb);
    end
    wb_read(32'h3000_0000, rd, lat);
    compared++;
    if (rd !== 32'h0 || lat !== 1) begin
      mismatched++;
      $display("[TB] FAIL dout_after_reset: got %h lat %0d expected 0 lat 1", rd, lat);
    end
  endtask

  // Safety net so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    io_in      = 16'h0000;
    bus_idle();
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_edge_irq();
    test_set_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
